// File: rtl/hdmi_rx_st_if.sv
// Avalon-ST source bus carrying one video line per packet.
// The master side drives data and packet markers; the slave side returns ready.
interface hdmi_rx_st_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  startofpacket;
  logic                  endofpacket;

  modport master (
    output valid,
    output data,
    output startofpacket,
    output endofpacket,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  startofpacket,
    input  endofpacket,
    output ready
  );
endinterface

// File: rtl/hdmi_rx_st.sv
// Parallel DE/VSYNC/RGB receiver: each active line becomes one Avalon-ST packet,
// buffered in a show-ahead FIFO, with sticky timing and overflow error flags.
module hdmi_rx_st #(
  parameter int DATA_WIDTH = 32,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int FIFO_DEPTH = 2048,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vid_de_i,
  input  logic             vid_vsync_i,
  input  logic [7:0]       vid_r_i,
  input  logic [7:0]       vid_g_i,
  input  logic [7:0]       vid_b_i,
  hdmi_rx_st_if.master     aso_src,
  output logic             frame_start_o,
  output logic [AW:0]      fifo_usedw_o,
  output logic             overflow_o,
  output logic             line_len_err_o,
  output logic             frame_len_err_o
);

  typedef enum logic [1:0] {IDLE, LINE_WAIT, ACTIVE} state_t;

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(FIFO_DEPTH);
  localparam logic [12:0] H_ACT_W   = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_W   = 13'(V_ACTIVE);
  localparam logic [12:0] CNT_MAX   = 13'h1FFF;

  function automatic logic [12:0] sat_inc(input logic [12:0] v);
    return (v == CNT_MAX) ? v : v + 13'd1;
  endfunction

  // Input stage S1 plus a second delay on de/vsync for edge detection
  logic        de_s1_q, vs_s1_q, de_s2_q, vs_s2_q;
  logic [23:0] pix_s1_q;

  state_t      state_q, state_d;
  logic [23:0] hold_pix_q, hold_pix_d;
  logic        hold_sop_q, hold_sop_d;
  logic [12:0] pix_cnt_q, pix_cnt_d;
  logic [12:0] line_cnt_q, line_cnt_d;
  logic        vs_seen_q, vs_seen_d;
  logic        frame_start_q, frame_start_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic [25:0] mem_q [FIFO_DEPTH];
  logic [25:0] push_word, head;
  logic        push, wr_en, pop, empty, full;
  logic [AW:0] usedw;
  logic        vs_fall, de_rise;

  assign vs_fall = vs_s2_q & ~vs_s1_q;
  assign de_rise = de_s1_q & ~de_s2_q;

  always_comb begin
    state_d       = state_q;
    hold_pix_d    = hold_pix_q;
    hold_sop_d    = hold_sop_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    vs_seen_d     = vs_seen_q;
    frame_start_d = 1'b0;
    line_err_d    = line_err_q;
    frame_err_d   = frame_err_q;
    push          = 1'b0;
    push_word     = {1'b0, hold_sop_q, hold_pix_q};

    if (vs_fall) begin
      // A frame boundary inside a line closes the partial packet
      if (state_q == ACTIVE) begin
        push        = 1'b1;
        push_word   = {1'b1, hold_sop_q, hold_pix_q};
        line_err_d  = 1'b1;
        frame_err_d = 1'b1;
      end
      if (vs_seen_q && (line_cnt_q != V_ACT_W)) frame_err_d = 1'b1;
      vs_seen_d     = 1'b1;
      frame_start_d = 1'b1;
      line_cnt_d    = '0;
      state_d       = LINE_WAIT;
    end else begin
      case (state_q)
        LINE_WAIT: begin
          if (de_rise) begin
            hold_pix_d = pix_s1_q;
            hold_sop_d = 1'b1;
            pix_cnt_d  = 13'd1;
            state_d    = ACTIVE;
          end
        end
        ACTIVE: begin
          push = 1'b1;
          if (de_s1_q) begin
            hold_pix_d = pix_s1_q;
            hold_sop_d = 1'b0;
            pix_cnt_d  = sat_inc(pix_cnt_q);
          end else begin
            push_word = {1'b1, hold_sop_q, hold_pix_q};
            if (pix_cnt_q != H_ACT_W) line_err_d = 1'b1;
            if (line_cnt_q >= V_ACT_W) frame_err_d = 1'b1;
            line_cnt_d = sat_inc(line_cnt_q);
            state_d    = LINE_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  // Show-ahead FIFO; a pop in the same cycle frees room for a push when full
  assign usedw = wr_ptr_q - rd_ptr_q;
  assign empty = (usedw == '0);
  assign full  = (usedw == DEPTH_W);
  assign pop   = ~empty & aso_src.ready;
  assign wr_en = push & (~full | pop);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      de_s2_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      pix_s1_q      <= '0;
      state_q       <= IDLE;
      hold_pix_q    <= '0;
      hold_sop_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      vs_seen_q     <= 1'b0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      ovf_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      de_s1_q       <= vid_de_i;
      vs_s1_q       <= vid_vsync_i;
      de_s2_q       <= de_s1_q;
      vs_s2_q       <= vs_s1_q;
      pix_s1_q      <= {vid_b_i, vid_g_i, vid_r_i};
      state_q       <= state_d;
      hold_pix_q    <= hold_pix_d;
      hold_sop_q    <= hold_sop_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      vs_seen_q     <= vs_seen_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      ovf_q         <= ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Head fields are masked while empty so stale RAM never reaches the bus
  always_comb begin
    aso_src.data          = '0;
    aso_src.data[23:0]    = empty ? 24'h0 : head[23:0];
    aso_src.valid         = ~empty;
    aso_src.startofpacket = ~empty & head[24];
    aso_src.endofpacket   = ~empty & head[25];
  end

  assign frame_start_o   = frame_start_q;
  assign fifo_usedw_o    = usedw;
  assign overflow_o      = ovf_q;
  assign line_len_err_o  = line_err_q;
  assign frame_len_err_o = frame_err_q;

endmodule

// File: tb/tb_hdmi_rx_st.sv
// Bench for hdmi_rx_st: directed frames with random pixels and ready, checked
// against a line-level model of expected packets and error flags.
module tb_hdmi_rx_st;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       de = 1'b0, vs = 1'b1;
  logic [7:0] r = 8'h0, g = 8'h0, b = 8'h0;

  hdmi_rx_st_if #(.DATA_WIDTH(DW)) bus_a ();
  hdmi_rx_st_if #(.DATA_WIDTH(DW)) bus_b ();

  logic       fs_a, ovf_a, lerr_a, ferr_a;
  logic [4:0] usedw_a;
  logic       fs_b, ovf_b, lerr_b, ferr_b;
  logic [2:0] usedw_b;

  hdmi_rx_st #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .vid_de_i(de), .vid_vsync_i(vs),
    .vid_r_i(r), .vid_g_i(g), .vid_b_i(b), .aso_src(bus_a.master),
    .frame_start_o(fs_a), .fifo_usedw_o(usedw_a), .overflow_o(ovf_a),
    .line_len_err_o(lerr_a), .frame_len_err_o(ferr_a)
  );

  hdmi_rx_st #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .vid_de_i(de), .vid_vsync_i(vs),
    .vid_r_i(r), .vid_g_i(g), .vid_b_i(b), .aso_src(bus_b.master),
    .frame_start_o(fs_b), .fifo_usedw_o(usedw_b), .overflow_o(ovf_b),
    .line_len_err_o(lerr_b), .frame_len_err_o(ferr_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Line-level reference model
  logic [25:0] exp_q[$];
  logic [25:0] last_line[$];
  logic [25:0] mon_e;
  bit  m_idle = 1'b1, m_seen = 1'b0, m_lerr = 1'b0, m_ferr = 1'b0;
  int  m_lines = 0;
  int  fs_cnt = 0, fs_exp = 0;
  bit  prev_fs = 1'b0;

  bit  rand_rdy = 1'b0;
  bit  rdy_a = 1'b1;
  logic ready_b = 1'b1;

  assign bus_b.ready = ready_b;

  always @(posedge clk) begin
    #2;
    bus_a.ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Output monitor for dut_a: every accepted word is matched against the model queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_a.valid && bus_a.ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word_count", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", 64'({bus_a.endofpacket, bus_a.startofpacket, bus_a.data}),
              64'({mon_e[25], mon_e[24], 8'h00, mon_e[23:0]}));
        end
      end
      if (fs_a) begin
        if (!prev_fs) fs_cnt++;
        else chk("frame_start_width", 64'(prev_fs), 64'd0);
      end
      prev_fs = fs_a;
    end else begin
      prev_fs = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_vsync();
    if (m_seen && m_lines != V) m_ferr = 1'b1;
    m_seen  = 1'b1;
    m_lines = 0;
    m_idle  = 1'b0;
    fs_exp++;
  endtask

  task automatic vsync_pulse();
    step();
    vs = 1'b0;
    model_vsync();
    repeat (3) step();
    vs = 1'b1;
    repeat (3) step();
  endtask

  // Drive an n-pixel line; optionally drop VSYNC together with DE
  task automatic send_line(input int n, input int l, input bit rnd, input bit vs_end);
    logic [23:0] p;
    last_line.delete();
    for (int i = 0; i < n; i++) begin
      step();
      de = 1'b1;
      p  = rnd ? 24'($urandom) : {8'hA5, 8'(l), 8'(i)};
      b  = p[23:16];
      g  = p[15:8];
      r  = p[7:0];
      last_line.push_back({(i == n - 1), (i == 0), p});
      if (!m_idle) exp_q.push_back({(i == n - 1), (i == 0), p});
    end
    step();
    de = 1'b0;
    if (vs_end) begin
      vs = 1'b0;
      if (!m_idle) begin
        m_lerr = 1'b1;
        m_ferr = 1'b1;
      end
      model_vsync();
      repeat (3) step();
      vs = 1'b1;
    end else if (!m_idle) begin
      if (n != H) m_lerr = 1'b1;
      m_lines++;
      if (m_lines > V) m_ferr = 1'b1;
    end
    repeat (2) step();
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    repeat (2) step();
    chk("drain_pending_words", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("reset_outputs_a", 64'({bus_a.valid, bus_a.startofpacket, bus_a.endofpacket, bus_a.data,
                                fs_a, usedw_a, ovf_a, lerr_a, ferr_a}), 64'd0);
    chk("reset_outputs_b", 64'({bus_b.valid, bus_b.startofpacket, bus_b.endofpacket, bus_b.data,
                                fs_b, usedw_b, ovf_b, lerr_b, ferr_b}), 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_idle  = 1'b1;
    m_seen  = 1'b0;
    m_lerr  = 1'b0;
    m_ferr  = 1'b0;
    m_lines = 0;
    fs_cnt  = 0;
    fs_exp  = 0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_line_err"}, 64'(lerr_a), 64'(m_lerr));
    chk({tag, "_frame_err"}, 64'(ferr_a), 64'(m_ferr));
    chk({tag, "_frame_starts"}, 64'(fs_cnt), 64'(fs_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    step();
    reset_n = 1'b1;
    model_reset();
    repeat (2) step();

    // DE before the first VSYNC fall is ignored
    send_line(4, 0, 1'b1, 1'b0);
    repeat (3) step();
    chk("idle_usedw", 64'(usedw_a), 64'd0);

    // Small patterned frame, ready held high
    vsync_pulse();
    for (int l = 0; l < V; l++) send_line(H, l, 1'b0, 1'b0);
    vsync_pulse();
    wait_drain(100);
    check_flags("pattern_frame");

    // Random pixels with random backpressure
    rand_rdy = 1'b1;
    for (int l = 0; l < V; l++) send_line(H, l, 1'b1, 1'b0);
    vsync_pulse();
    wait_drain(400);
    rand_rdy = 1'b0;
    check_flags("random_frame");

    // Whole line held back, then released
    rdy_a = 1'b0;
    send_line(H, 0, 1'b1, 1'b0);
    repeat (3) step();
    chk("bp_usedw_peak", 64'(usedw_a), 64'd4);
    chk("bp_valid", 64'(bus_a.valid), 64'd1);
    rdy_a = 1'b1;
    wait_drain(100);
    chk("bp_usedw_empty", 64'(usedw_a), 64'd0);

    // Short line
    send_line(3, 1, 1'b1, 1'b0);
    wait_drain(100);
    check_flags("short_line");

    // VSYNC falls after two pixels, then a fresh packet
    send_line(2, 2, 1'b1, 1'b1);
    repeat (2) step();
    send_line(H, 0, 1'b1, 1'b0);
    wait_drain(100);
    check_flags("vsync_midline");

    // Reset in the middle of a line with words held in the FIFO
    rdy_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      de = 1'b1;
      {b, g, r} = 24'($urandom);
    end
    step();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    de = 1'b0;
    repeat (4) step();
    chk("post_reset_usedw", 64'(usedw_a), 64'd0);
    chk("post_reset_valid", 64'(bus_a.valid), 64'd0);
    rdy_a = 1'b1;

    // Overflow on the 4-deep instance: 6-pixel line with ready low
    ready_b = 1'b0;
    vsync_pulse();
    send_line(6, 0, 1'b1, 1'b0);
    repeat (3) step();
    chk("ovf_usedw", 64'(usedw_b), 64'd4);
    chk("ovf_flag", 64'(ovf_b), 64'd1);
    ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ovf_word", 64'({bus_b.endofpacket, bus_b.startofpacket, bus_b.data}),
          64'({last_line[i][25], last_line[i][24], 8'h00, last_line[i][23:0]}));
    end
    @(negedge clk);
    chk("ovf_drained_valid", 64'(bus_b.valid), 64'd0);
    chk("ovf_flag_sticky", 64'(ovf_b), 64'd1);
    step();

    wait_drain(100);
    check_flags("final");
    chk("no_overflow_a", 64'(ovf_a), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
